// File: rtl/spi_flash_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// spi_flash_bus_arbiter_if
//
// Purpose: gathers every pin of the SPI flash arbiter except clk and reset.
// These are the flash read controller side (i_M_*, o_M_*), the host
// programming side (i_H_*, i_HOST_REQ, o_H_*, o_HOST_GNT), the board flash
// pins (o_SPI_*, i_SPI_MISO), the 6809 stall output and the debug state.
//
// Modports:
//   master : the surroundings of the arbiter. It drives the request and data
//            inputs and observes the outputs.
//   slave  : the arbiter itself.
//
// Handshake semantics, stated once: the host asks for the flash by holding
// i_HOST_REQ high. It may drive the flash only while o_HOST_GNT is high. It
// gives the flash back by dropping i_HOST_REQ, and the release takes effect
// only once its CS (i_H_SPI_CS) is high. The CPU side is stalled by
// o_MemoryReady=0. A CPU read is accepted only while o_M_CE follows
// i_spi_ce.
// -----------------------------------------------------------------------------
interface spi_flash_bus_arbiter_if;
   // CPU / flash read controller side
   logic       i_spi_ce;
   logic       i_RW;
   logic       i_M_SPI_CLK;
   logic       i_M_SPI_MOSI;
   logic       i_M_SPI_CS;
   logic       i_M_READY;
   logic       o_M_CE;
   logic       o_M_SPI_MISO;
   // Host programming port side
   logic       i_HOST_REQ;
   logic       i_H_SPI_CLK;
   logic       i_H_SPI_MOSI;
   logic       i_H_SPI_CS;
   logic       o_HOST_GNT;
   logic       o_H_SPI_MISO;
   // Flash pins
   logic       i_SPI_MISO;
   logic       o_SPI_CLK;
   logic       o_SPI_MOSI;
   logic       o_SPI_CS;
   // 6809 stall and debug
   logic       o_MemoryReady;
   logic [2:0] o_STATE;

   modport master (
      output i_spi_ce, i_RW, i_M_SPI_CLK, i_M_SPI_MOSI, i_M_SPI_CS, i_M_READY,
      output i_HOST_REQ, i_H_SPI_CLK, i_H_SPI_MOSI, i_H_SPI_CS, i_SPI_MISO,
      input  o_M_CE, o_M_SPI_MISO, o_HOST_GNT, o_H_SPI_MISO,
      input  o_SPI_CLK, o_SPI_MOSI, o_SPI_CS, o_MemoryReady, o_STATE
   );

   modport slave (
      input  i_spi_ce, i_RW, i_M_SPI_CLK, i_M_SPI_MOSI, i_M_SPI_CS, i_M_READY,
      input  i_HOST_REQ, i_H_SPI_CLK, i_H_SPI_MOSI, i_H_SPI_CS, i_SPI_MISO,
      output o_M_CE, o_M_SPI_MISO, o_HOST_GNT, o_H_SPI_MISO,
      output o_SPI_CLK, o_SPI_MOSI, o_SPI_CS, o_MemoryReady, o_STATE
   );
endinterface

// File: rtl/spi_flash_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_flash_bus_arbiter
//
// Purpose: shares one SPI flash between the on-chip 6809 flash read
// controller and the FT2232 host programming port. The arbiter owns the flash
// pins and routes MISO back to whichever master currently owns the flash.
// Ownership changes only at transaction boundaries. Every change of owner
// passes through a CS-high / CLK-low guard interval. While the flash is not
// owned by the CPU side, CPU flash reads are stalled through o_MemoryReady.
//
// Ports:
//   clk    : system clock, the only clock.
//   reset  : asynchronous, active-low reset. While it is low, the flash pins
//            are forced idle and every output takes its safe value.
//   bus    : spi_flash_bus_arbiter_if.slave. All CPU, host and flash pins
//            plus the o_STATE debug output.
//
// Parameters:
//   GUARD_CYCLES : clk cycles of forced idle on each ownership change (1..255).
//
// o_STATE encoding: CPU_OWN=0, DRAIN=1, GUARD_H=2, HOST_OWN=3, GUARD_C=4.
// -----------------------------------------------------------------------------
module spi_flash_bus_arbiter #(
   parameter int GUARD_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   spi_flash_bus_arbiter_if.slave  bus
);

   typedef enum logic [2:0] {
      CPU_OWN  = 3'd0,
      DRAIN    = 3'd1,
      GUARD_H  = 3'd2,
      HOST_OWN = 3'd3,
      GUARD_C  = 3'd4
   } state_t;

   // The counter counts down to zero inclusive. Loading GUARD_CYCLES-1 gives
   // exactly GUARD_CYCLES cycles spent in a guard state.
   localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] guard_cnt;
   logic [7:0] guard_cnt_nxt;
   logic       gnt_q;

   // 2-flop synchronizers for the two host signals that are asynchronous to clk.
   logic req_meta;
   logic req_s;
   logic hcs_meta;
   logic hcs_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_meta <= 1'b0;
         req_s    <= 1'b0;
         hcs_meta <= 1'b0;
         hcs_s    <= 1'b0;
      end else begin
         req_meta <= bus.i_HOST_REQ;
         req_s    <= req_meta;
         hcs_meta <= bus.i_H_SPI_CS;
         hcs_s    <= hcs_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // State register. The grant is registered from the next state, so it rises
   // on the same edge on which HOST_OWN is entered.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= CPU_OWN;
         guard_cnt <= 8'd0;
         gnt_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         guard_cnt <= guard_cnt_nxt;
         gnt_q     <= (state_nxt == HOST_OWN);
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      guard_cnt_nxt = guard_cnt;
      unique case (state)
         CPU_OWN: begin
            if (req_s) state_nxt = DRAIN;
         end
         DRAIN: begin
            // A withdrawn request wins over a completed CPU transaction.
            if (!req_s) begin
               state_nxt = CPU_OWN;
            end else if (bus.i_M_SPI_CS && bus.i_M_READY) begin
               state_nxt     = GUARD_H;
               guard_cnt_nxt = GUARD_LOAD;
            end
         end
         GUARD_H: begin
            if (guard_cnt == 8'd0) state_nxt = HOST_OWN;
            else                   guard_cnt_nxt = guard_cnt - 8'd1;
         end
         HOST_OWN: begin
            // The host keeps the flash until its CS is high, so a host
            // transaction is never cut short by a dropped request.
            if (!req_s && hcs_s) begin
               state_nxt     = GUARD_C;
               guard_cnt_nxt = GUARD_LOAD;
            end
         end
         GUARD_C: begin
            if (guard_cnt == 8'd0) state_nxt = CPU_OWN;
            else                   guard_cnt_nxt = guard_cnt - 8'd1;
         end
         default: begin
            state_nxt     = CPU_OWN;
            guard_cnt_nxt = 8'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic: pin muxes and the stall signal, combinational from the
   // registered state. Reset is folded in so that asserting reset idles the
   // flash pins in the same cycle, without waiting for a clock edge.
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.o_SPI_CS      = 1'b1;
      bus.o_SPI_CLK     = 1'b0;
      bus.o_SPI_MOSI    = 1'b0;
      bus.o_M_CE        = 1'b0;
      bus.o_MemoryReady = 1'b1;
      bus.o_M_SPI_MISO  = 1'b0;
      bus.o_H_SPI_MISO  = 1'b0;
      bus.o_HOST_GNT    = 1'b0;
      bus.o_STATE       = CPU_OWN;
      if (reset) begin
         bus.o_STATE    = state;
         bus.o_HOST_GNT = gnt_q;
         // Away from CPU_OWN, only CPU flash reads are stalled.
         bus.o_MemoryReady = ~(bus.i_spi_ce & bus.i_RW);
         unique case (state)
            CPU_OWN: begin
               bus.o_SPI_CS      = bus.i_M_SPI_CS;
               bus.o_SPI_CLK     = bus.i_M_SPI_CLK;
               bus.o_SPI_MOSI    = bus.i_M_SPI_MOSI;
               bus.o_M_CE        = bus.i_spi_ce;
               bus.o_MemoryReady = bus.i_M_READY;
               bus.o_M_SPI_MISO  = bus.i_SPI_MISO;
            end
            DRAIN: begin
               // The pins stay on the controller so an in-flight read can
               // finish, but no new CPU transaction can start.
               bus.o_SPI_CS     = bus.i_M_SPI_CS;
               bus.o_SPI_CLK    = bus.i_M_SPI_CLK;
               bus.o_SPI_MOSI   = bus.i_M_SPI_MOSI;
               bus.o_M_SPI_MISO = bus.i_SPI_MISO;
            end
            HOST_OWN: begin
               bus.o_SPI_CS     = bus.i_H_SPI_CS;
               bus.o_SPI_CLK    = bus.i_H_SPI_CLK;
               bus.o_SPI_MOSI   = bus.i_H_SPI_MOSI;
               bus.o_H_SPI_MISO = bus.i_SPI_MISO;
            end
            default: begin
               // Guard states keep the idle pin values set above.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_bus_arbiter
//
// Bench for the SPI flash arbiter. Inputs change just after the falling edge.
// Outputs are compared 1 time unit later, against a reference model that
// tracks owner, sync history and remaining guard cycles. The reference model
// advances on each rising edge. Directed handoff, drain, host-CS-held, stall,
// abort and reset scenarios come first, then a randomized soak with
// occasional resets.
// -----------------------------------------------------------------------------
module tb_spi_flash_bus_arbiter;

   localparam int GUARD_CYCLES = 4;
   localparam int W            = 11;

   // --------------------------------------------------------------------------
   // Clock / reset
   // --------------------------------------------------------------------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   spi_flash_bus_arbiter_if bus ();

   spi_flash_bus_arbiter #(.GUARD_CYCLES(GUARD_CYCLES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // --------------------------------------------------------------------------
   // Reference model. The owner phase uses the o_STATE numbering. Guard time
   // is tracked as "cycles still to spend" (starting at GUARD_CYCLES).
   // --------------------------------------------------------------------------
   int   m_phase;
   int   m_guard_left;
   logic m_req_hist [2];   // [0] newest, [1] = synchronized value
   logic m_hcs_hist [2];

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   logic [W-1:0] exp_q [$];

   task automatic model_reset();
      m_phase       = 0;
      m_guard_left  = 0;
      m_req_hist[0] = 1'b0;
      m_req_hist[1] = 1'b0;
      m_hcs_hist[0] = 1'b0;
      m_hcs_hist[1] = 1'b0;
   endtask

   // One rising edge: decisions use the synchronized values from before the edge.
   task automatic model_step();
      logic rq;
      logic hc;
      rq = m_req_hist[1];
      hc = m_hcs_hist[1];
      case (m_phase)
         0: if (rq) m_phase = 1;
         1: begin
            if (!rq) m_phase = 0;
            else if (bus.i_M_SPI_CS && bus.i_M_READY) begin
               m_phase      = 2;
               m_guard_left = GUARD_CYCLES;
            end
         end
         2, 4: begin
            m_guard_left--;
            if (m_guard_left == 0) m_phase = (m_phase == 2) ? 3 : 0;
         end
         3: if (!rq && hc) begin
            m_phase      = 4;
            m_guard_left = GUARD_CYCLES;
         end
         default: m_phase = 0;
      endcase
      m_req_hist[1] = m_req_hist[0];
      m_req_hist[0] = bus.i_HOST_REQ;
      m_hcs_hist[1] = m_hcs_hist[0];
      m_hcs_hist[0] = bus.i_H_SPI_CS;
   endtask

   // Expected output word:
   // {state[2:0], gnt, cs, sclk, mosi, m_ce, mem_rdy, m_miso, h_miso}
   function automatic logic [W-1:0] expected_word();
      logic       cpu_pins;
      logic       host_pins;
      logic       cs, sck, mosi, mce, rdy, mmiso, hmiso;
      if (!reset) return {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      cpu_pins  = (m_phase == 0) || (m_phase == 1);
      host_pins = (m_phase == 3);
      cs    = cpu_pins ? bus.i_M_SPI_CS   : host_pins ? bus.i_H_SPI_CS   : 1'b1;
      sck   = cpu_pins ? bus.i_M_SPI_CLK  : host_pins ? bus.i_H_SPI_CLK  : 1'b0;
      mosi  = cpu_pins ? bus.i_M_SPI_MOSI : host_pins ? bus.i_H_SPI_MOSI : 1'b0;
      mce   = (m_phase == 0) ? bus.i_spi_ce : 1'b0;
      rdy   = (m_phase == 0) ? bus.i_M_READY : !(bus.i_spi_ce && bus.i_RW);
      mmiso = cpu_pins  ? bus.i_SPI_MISO : 1'b0;
      hmiso = host_pins ? bus.i_SPI_MISO : 1'b0;
      return {3'(m_phase), host_pins, cs, sck, mosi, mce, rdy, mmiso, hmiso};
   endfunction

   // --------------------------------------------------------------------------
   // Checking
   // --------------------------------------------------------------------------
   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
      end
   endtask

   task automatic compare_outputs();
      logic [W-1:0] e;
      exp_q.push_back(expected_word());
      e = exp_q.pop_front();
      check_val("o_STATE",       8'(bus.o_STATE),       8'(e[10:8]));
      check_val("o_HOST_GNT",    8'(bus.o_HOST_GNT),    8'(e[7]));
      check_val("o_SPI_CS",      8'(bus.o_SPI_CS),      8'(e[6]));
      check_val("o_SPI_CLK",     8'(bus.o_SPI_CLK),     8'(e[5]));
      check_val("o_SPI_MOSI",    8'(bus.o_SPI_MOSI),    8'(e[4]));
      check_val("o_M_CE",        8'(bus.o_M_CE),        8'(e[3]));
      check_val("o_MemoryReady", 8'(bus.o_MemoryReady), 8'(e[2]));
      check_val("o_M_SPI_MISO",  8'(bus.o_M_SPI_MISO),  8'(e[1]));
      check_val("o_H_SPI_MISO",  8'(bus.o_H_SPI_MISO),  8'(e[0]));
   endtask

   // --------------------------------------------------------------------------
   // Driver tasks. Callers set inputs just after a falling edge, then call tick.
   // --------------------------------------------------------------------------
   task automatic tick();
      #1;
      compare_outputs();
      @(posedge clk);
      if (reset) model_step();
      else       model_reset();
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.i_spi_ce     = 1'b0;
      bus.i_RW         = 1'b1;
      bus.i_M_SPI_CLK  = 1'b0;
      bus.i_M_SPI_MOSI = 1'b0;
      bus.i_M_SPI_CS   = 1'b1;
      bus.i_M_READY    = 1'b1;
      bus.i_HOST_REQ   = 1'b0;
      bus.i_H_SPI_CLK  = 1'b0;
      bus.i_H_SPI_MOSI = 1'b0;
      bus.i_H_SPI_CS   = 1'b1;
      bus.i_SPI_MISO   = 1'b0;
   endtask

   task automatic random_data_pins();
      bus.i_spi_ce     = 1'($urandom_range(0, 1));
      bus.i_RW         = 1'($urandom_range(0, 1));
      bus.i_M_SPI_CLK  = 1'($urandom_range(0, 1));
      bus.i_M_SPI_MOSI = 1'($urandom_range(0, 1));
      bus.i_H_SPI_CLK  = 1'($urandom_range(0, 1));
      bus.i_H_SPI_MOSI = 1'($urandom_range(0, 1));
      bus.i_SPI_MISO   = 1'($urandom_range(0, 1));
   endtask

   task automatic random_cycle();
      random_data_pins();
      bus.i_M_SPI_CS = ($urandom_range(0, 3) != 0);
      bus.i_M_READY  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) bus.i_HOST_REQ = ~bus.i_HOST_REQ;
      if ($urandom_range(0, 3) == 0)  bus.i_H_SPI_CS = ~bus.i_H_SPI_CS;
   endtask

   // Ticks until o_STATE equals want, at most budget ticks; returns ticks used.
   task automatic wait_state(input logic [2:0] want, input int budget, output int used);
      used = 0;
      while (bus.o_STATE !== want && used < budget) begin
         tick();
         used++;
      end
   endtask

   // --------------------------------------------------------------------------
   // Stimulus
   // --------------------------------------------------------------------------
   initial begin : main
      int k;
      int ticks;
      logic saw_gnt;

      idle_inputs();
      model_reset();
      reset = 1'b0;
      @(negedge clk);
      tick();
      tick();
      reset = 1'b1;
      tick();

      // Idle handoff: 3 edges to DRAIN, 1 to GUARD_H, GUARD_CYCLES to HOST_OWN.
      bus.i_HOST_REQ = 1'b1;
      ticks = 0;
      while (bus.o_HOST_GNT !== 1'b1 && ticks < 20) begin
         tick();
         ticks++;
      end
      check_val("idle_handoff_latency", 8'(ticks), 8'(3 + 1 + GUARD_CYCLES));
      bus.i_H_SPI_CS  = 1'b0;
      bus.i_H_SPI_CLK = 1'b1;
      #1;
      check_val("host_clk_on_pin", 8'(bus.o_SPI_CLK), 8'd1);
      check_val("host_cs_on_pin", 8'(bus.o_SPI_CS), 8'd0);
      tick();

      // CPU read while host owns: stalled.
      bus.i_spi_ce = 1'b1;
      bus.i_RW     = 1'b1;
      bus.i_M_READY = 1'b1;
      #1;
      check_val("cpu_stall_rdy", 8'(bus.o_MemoryReady), 8'd0);
      check_val("cpu_stall_ce", 8'(bus.o_M_CE), 8'd0);
      tick();

      // Host CS held low while the request drops: ownership stays with host.
      bus.i_HOST_REQ = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check_val("host_cs_held_state", 8'(bus.o_STATE), 8'd3);
      bus.i_H_SPI_CS = 1'b1;
      wait_state(3'd0, 20, ticks);
      check_val("release_latency", 8'(ticks), 8'(3 + GUARD_CYCLES));
      #1;
      check_val("stall_released", 8'(bus.o_MemoryReady), 8'(bus.i_M_READY));
      check_val("cpu_ce_back", 8'(bus.o_M_CE), 8'd1);
      tick();

      // Drain: CPU read in flight when the request arrives.
      bus.i_M_SPI_CS = 1'b0;
      bus.i_M_READY  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.i_M_SPI_CLK = ~bus.i_M_SPI_CLK;
         tick();
      end
      bus.i_HOST_REQ = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.i_M_SPI_CLK  = ~bus.i_M_SPI_CLK;
         bus.i_M_SPI_MOSI = 1'($urandom_range(0, 1));
         bus.i_SPI_MISO   = 1'($urandom_range(0, 1));
         tick();
      end
      check_val("drain_state", 8'(bus.o_STATE), 8'd1);
      check_val("drain_ce_gated", 8'(bus.o_M_CE), 8'd0);
      check_val("drain_pins_cpu", 8'(bus.o_SPI_CLK), 8'(bus.i_M_SPI_CLK));
      bus.i_M_SPI_CS  = 1'b1;
      bus.i_M_READY   = 1'b1;
      bus.i_M_SPI_CLK = 1'b0;
      ticks = 0;
      while (bus.o_HOST_GNT !== 1'b1 && ticks < 20) begin
         tick();
         ticks++;
      end
      check_val("drain_to_gnt", 8'(ticks), 8'(1 + GUARD_CYCLES));

      // Release and then abort a short request during a CPU read.
      bus.i_HOST_REQ = 1'b0;
      wait_state(3'd0, 20, ticks);
      check_val("back_to_cpu", 8'(bus.o_STATE), 8'd0);
      bus.i_M_SPI_CS = 1'b0;
      bus.i_M_READY  = 1'b0;
      bus.i_HOST_REQ = 1'b1;
      saw_gnt = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i == 3) bus.i_HOST_REQ = 1'b0;
         bus.i_M_SPI_CLK = ~bus.i_M_SPI_CLK;
         bus.i_SPI_MISO  = 1'($urandom_range(0, 1));
         if (bus.o_HOST_GNT === 1'b1) saw_gnt = 1'b1;
         tick();
      end
      check_val("abort_no_gnt", 8'(saw_gnt), 8'd0);
      check_val("abort_back_cpu", 8'(bus.o_STATE), 8'd0);

      // Reset mid-read: pins idle and state cleared without a clock edge.
      bus.i_M_SPI_CLK = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      check_val("rst_cs", 8'(bus.o_SPI_CS), 8'd1);
      check_val("rst_clk", 8'(bus.o_SPI_CLK), 8'd0);
      check_val("rst_state", 8'(bus.o_STATE), 8'd0);
      check_val("rst_rdy", 8'(bus.o_MemoryReady), 8'd1);
      @(negedge clk);
      model_reset();
      tick();
      reset = 1'b1;
      idle_inputs();
      tick();

      // Randomized soak with occasional resets.
      for (k = 0; k < 4000; k++) begin
         random_cycle();
         if ($urandom_range(0, 499) == 0) reset = 1'b0;
         else                              reset = 1'b1;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Overall time bound.
   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete (checks %0d)", n_checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/spi_flash_bus_arbiter.md
# spi_flash_bus_arbiter

Shares the single SPI flash between two masters: the on-chip 6809 flash read controller (CPU side) and the FT2232 host programming port (host side). It owns the flash pins (CS, CLK, MOSI), routes MISO, hands ownership over only at transaction boundaries with a CS-high guard interval, and stalls the 6809 through MemoryReady while the host owns the flash. It sits between the address decoder / flash read controller and the board-level flash pins.

## Interface
- GUARD_CYCLES, 4: clk cycles of forced CS-high/CLK-low idle on every ownership change, range 1..255.
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- i_spi_ce  in  1  flash chip-select from the address decoder.
- i_RW  in  1  6809 R/W (1 = read).
- i_M_SPI_CLK  in  1  flash read controller SPI clock.
- i_M_SPI_MOSI  in  1  flash read controller SPI MOSI.
- i_M_SPI_CS  in  1  flash read controller SPI CS, active low.
- i_M_READY  in  1  flash read controller MemoryReady (0 = transaction in progress).
- o_M_CE  out  1  gated chip-select to the flash read controller.
- o_M_SPI_MISO  out  1  MISO to the flash read controller.
- i_HOST_REQ  in  1  host ownership request, asynchronous to clk.
- i_H_SPI_CLK  in  1  host SPI clock.
- i_H_SPI_MOSI  in  1  host SPI MOSI.
- i_H_SPI_CS  in  1  host SPI CS, active low, asynchronous to clk.
- o_HOST_GNT  out  1  host owns the flash pins.
- o_H_SPI_MISO  out  1  MISO to the host.
- i_SPI_MISO  in  1  flash MISO.
- o_SPI_CLK  out  1  flash SPI clock.
- o_SPI_MOSI  out  1  flash SPI MOSI.
- o_SPI_CS  out  1  flash SPI CS, active low.
- o_MemoryReady  out  1  wait-state signal to the 6809 (0 = stall).
- o_STATE  out  3  current state encoding, for debug.

## Operation
- i_HOST_REQ and i_H_SPI_CS each pass through a 2-flop synchronizer: req_s and hcs_s. All decisions use the synchronized versions. Host data pins are muxed combinationally.
- States (o_STATE): CPU_OWN=0, DRAIN=1, GUARD_H=2, HOST_OWN=3, GUARD_C=4. A 8-bit guard counter serves both guard states.
- CPU_OWN: flash pins = i_M_*. o_M_CE = i_spi_ce. o_MemoryReady = i_M_READY. If req_s=1, go to DRAIN.
- DRAIN:
  - o_M_CE = 0, so no new CPU transaction can start.
  - Pins stay on i_M_* so any in-flight transaction completes.
  - When i_M_SPI_CS=1 and i_M_READY=1 in the same cycle, load the counter with GUARD_CYCLES-1 and go to GUARD_H.
  - If req_s drops while in DRAIN, return to CPU_OWN.
- GUARD_H and GUARD_C:
  - Pins forced to o_SPI_CS=1, o_SPI_CLK=0, o_SPI_MOSI=0; o_M_CE=0.
  - The counter decrements each cycle. At 0: GUARD_H goes to HOST_OWN; GUARD_C goes to CPU_OWN.
- HOST_OWN:
  - o_HOST_GNT=1; pins = i_H_*; o_M_CE=0.
  - When req_s=0 and hcs_s=1, load the counter and go to GUARD_C.
  - If req_s drops while hcs_s=0, stay in HOST_OWN until the host CS rises, so a host transaction is never truncated.
- In every state other than CPU_OWN: o_MemoryReady = ~(i_spi_ce & i_RW). CPU flash reads stall; other CPU cycles proceed.
- MISO routing:
  - o_M_SPI_MISO = i_SPI_MISO in CPU_OWN and DRAIN, else 0.
  - o_H_SPI_MISO = i_SPI_MISO in HOST_OWN, else 0.
- CPU writes (i_RW=0) to flash space are passed to o_M_CE unchanged in CPU_OWN; the read controller ignores them.

## Timing
- Reset is asynchronous. While reset=0, outputs are forced to:
  - o_SPI_CS=1, o_SPI_CLK=0, o_SPI_MOSI=0
  - o_HOST_GNT=0, o_M_CE=0, o_MemoryReady=1
  - o_M_SPI_MISO=0, o_H_SPI_MISO=0
  - o_STATE=CPU_OWN
- The synchronizers and counter clear during reset. Reset mid-transaction by either master aborts it immediately with CS high.
- Request latency:
  - i_HOST_REQ rise to DRAIN: 2-3 clk.
  - Idle CPU: DRAIN to GUARD_H takes 1 clk.
  - o_HOST_GNT rises GUARD_CYCLES clk after entering GUARD_H.
  - Worst case adds one full CPU transaction (about 82 clk) in DRAIN.
- Release latency: host CS high and req low (synchronized, 2-3 clk), then GUARD_CYCLES clk in GUARD_C, then CPU_OWN.
- The state register and o_HOST_GNT are registered. Pin muxes and o_MemoryReady are combinational from the registered state.
- Simultaneous events:
  - i_spi_ce rising in the same cycle DRAIN is entered is gated off; that read stalls until the return to CPU_OWN.
  - req_s low together with the DRAIN exit condition: req_s wins and the next state is CPU_OWN.
- There is no host timeout. The host holds ownership for as long as i_HOST_REQ=1.

## Test plan
- Reset mid-read: controller CS low, drive reset=0 -> o_SPI_CS=1, o_SPI_CLK=0, o_STATE=0 in the same cycle; o_MemoryReady=1.
- Idle handoff: CPU idle, GUARD_CYCLES=4, raise i_HOST_REQ -> DRAIN within 3 clk, GUARD_H for 4 clk with CS high, then o_HOST_GNT=1; i_H_SPI_CLK toggles appear on o_SPI_CLK.
- Drain: start a CPU read at 0x1234, then raise i_HOST_REQ 10 clk later -> the read completes with all 40 bits, o_M_CE=0 after DRAIN entry, o_HOST_GNT rises only after i_M_SPI_CS=1 plus 4 clk.
- CPU stall: host owns, CPU asserts i_spi_ce=1 with i_RW=1 -> o_MemoryReady=0 throughout; release the host -> the read executes after GUARD_C and o_MemoryReady returns to 1.
- Host CS held: drop i_HOST_REQ while i_H_SPI_CS=0 -> state stays 3 and the pins stay on the host; raise the host CS -> GUARD_C, then CPU_OWN 4 clk later.
- Aborted request: pulse i_HOST_REQ for 3 clk while a CPU read is in flight -> DRAIN then back to CPU_OWN; o_HOST_GNT never rises and the read data is unaffected.
